// File: rtl/ysyx_22041752_wb_arb.sv
// Write-back arbiter: two producer FIFOs (EXU, LSU) share one register-file
// write port under round-robin arbitration; a pending-write scoreboard lets
// decode detect RAW hazards on in-flight destinations.
module ysyx_22041752_wb_arb #(
   parameter int unsigned RF_ADDR_WD = 5,
   parameter int unsigned RF_DATA_WD = 64,
   parameter int unsigned RF_NUM     = 32,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_exu_valid,
   output logic                  o_exu_ready,
   input  logic [RF_ADDR_WD-1:0] i_exu_rd,
   input  logic [RF_DATA_WD-1:0] i_exu_data,
   input  logic                  i_lsu_valid,
   output logic                  o_lsu_ready,
   input  logic [RF_ADDR_WD-1:0] i_lsu_rd,
   input  logic [RF_DATA_WD-1:0] i_lsu_data,
   output logic                  o_rf_we,
   output logic [RF_ADDR_WD-1:0] o_rf_addr_w,
   output logic [RF_DATA_WD-1:0] o_rf_data_w,
   input  logic                  i_sb_set,
   input  logic [RF_ADDR_WD-1:0] i_sb_rd,
   input  logic [RF_ADDR_WD-1:0] i_chk_r1,
   input  logic [RF_ADDR_WD-1:0] i_chk_r2,
   output logic                  o_busy_r1,
   output logic                  o_busy_r2,
   output logic                  o_idle
);

   localparam int unsigned NPROD = 2;   // index 0 = EXU, 1 = LSU
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

   logic [NPROD-1:0]                 w_in_valid;
   logic [NPROD-1:0][RF_ADDR_WD-1:0] w_in_rd;
   logic [NPROD-1:0][RF_DATA_WD-1:0] w_in_data;
   logic [NPROD-1:0]                 w_full;
   logic [NPROD-1:0]                 w_empty;
   logic [NPROD-1:0]                 w_push;
   logic [NPROD-1:0]                 w_gnt;
   logic [NPROD-1:0][RF_ADDR_WD-1:0] w_head_rd;
   logic [NPROD-1:0][RF_DATA_WD-1:0] w_head_data;
   logic [RF_ADDR_WD-1:0]            w_sel_rd;
   logic [RF_DATA_WD-1:0]            w_sel_data;
   logic [RF_NUM-1:0]                w_sb_nxt;

   logic                             r_pri_lsu;   // 1: LSU wins the next tie
   logic [RF_NUM-1:0]                r_sb;

   assign w_in_valid = {i_lsu_valid, i_exu_valid};
   assign w_in_rd    = {i_lsu_rd,    i_exu_rd};
   assign w_in_data  = {i_lsu_data,  i_exu_data};

   for (genvar g = 0; g < NPROD; g++) begin : g_fifo
      logic [RF_ADDR_WD-1:0] r_rd   [FIFO_DEPTH];
      logic [RF_DATA_WD-1:0] r_data [FIFO_DEPTH];
      logic [PTR_W-1:0]      r_wptr;
      logic [PTR_W-1:0]      r_rptr;
      logic [CNT_W-1:0]      r_cnt;

      assign w_full[g]      = (r_cnt == CNT_W'(FIFO_DEPTH));
      assign w_empty[g]     = (r_cnt == '0);
      assign w_push[g]      = w_in_valid[g] && !w_full[g];
      assign w_head_rd[g]   = r_rd[r_rptr];
      assign w_head_data[g] = r_data[r_rptr];

      // Pointer and occupancy bookkeeping; pop is the arbiter grant
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_push[g])
               r_wptr <= (r_wptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
            if (w_gnt[g])
               r_rptr <= (r_rptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
            if (w_push[g] && !w_gnt[g])
               r_cnt <= r_cnt + CNT_W'(1);
            else if (!w_push[g] && w_gnt[g])
               r_cnt <= r_cnt - CNT_W'(1);
         end
      end

      // Payload storage; contents are only meaningful while counted
      always_ff @(posedge clk) begin
         if (w_push[g]) begin
            r_rd[r_wptr]   <= w_in_rd[g];
            r_data[r_wptr] <= w_in_data[g];
         end
      end
   end

   // Round-robin grant over the two FIFO heads
   always_comb begin
      w_gnt = '0;
      if (!w_empty[0] && !w_empty[1])
         w_gnt = r_pri_lsu ? 2'b10 : 2'b01;
      else if (!w_empty[0])
         w_gnt = 2'b01;
      else if (!w_empty[1])
         w_gnt = 2'b10;
   end

   // Write-port drive; x0 entries are consumed silently
   always_comb begin
      w_sel_rd    = w_gnt[1] ? w_head_rd[1]   : w_head_rd[0];
      w_sel_data  = w_gnt[1] ? w_head_data[1] : w_head_data[0];
      o_rf_we     = 1'b0;
      o_rf_addr_w = '0;
      o_rf_data_w = '0;
      if ((|w_gnt) && (w_sel_rd != '0)) begin
         o_rf_we     = 1'b1;
         o_rf_addr_w = w_sel_rd;
         o_rf_data_w = w_sel_data;
      end
   end

   // Scoreboard next state: commit clears, issue sets, set wins on collision
   always_comb begin
      w_sb_nxt = r_sb;
      if (o_rf_we)
         w_sb_nxt[o_rf_addr_w] = 1'b0;
      if (i_sb_set && (i_sb_rd != '0))
         w_sb_nxt[i_sb_rd] = 1'b1;
      w_sb_nxt[0] = 1'b0;
   end

   // Last-grant tracking and scoreboard register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pri_lsu <= 1'b0;
         r_sb      <= '0;
      end else begin
         if (|w_gnt)
            r_pri_lsu <= w_gnt[0];
         r_sb <= w_sb_nxt;
      end
   end

   assign o_exu_ready = !w_full[0];
   assign o_lsu_ready = !w_full[1];
   assign o_busy_r1   = r_sb[i_chk_r1];
   assign o_busy_r2   = r_sb[i_chk_r2];
   assign o_idle      = w_empty[0] && w_empty[1] && (r_sb == '0);

endmodule
